// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared definitions for the framebuffer arbiter slice.
//                Panel geometry, the word address/data widths that follow
//                from it, and the memory-command FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W         = 120;
    localparam int FB_H         = 68;
    localparam int PIX_PER_WORD = 4;
    localparam int BPP          = 4;

    // 120 x 68 pixels packed 4 per word -> 2040 words
    localparam int FB_WORDS  = (FB_W * FB_H) / PIX_PER_WORD;
    localparam int FB_ADDR_W = $clog2(FB_WORDS);
    localparam int FB_DATA_W = PIX_PER_WORD * BPP;

    // Registered memory command: IDLE drives no strobe, ACCESS strobes mem_ce_o
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_rdpipe.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rdpipe
//  Description : DEPTH-deep valid shift register tracking issued display
//                reads until their data leaves the block RAM.
//  Ports       : clk      - pixel clock
//                rst      - synchronous clear, discards reads in flight
//                i_issue  - a display read is on the memory port this cycle
//                o_valid  - read data is on the memory read bus this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module fb_rdpipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    output logic o_valid
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= i_issue;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else begin
                    r_sr <= {r_sr[DEPTH-2:0], i_issue};
                end
            end
        end
    endgenerate

    assign o_valid = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Shares one single-port framebuffer BSRAM between the LCD
//                display fetch path (reads) and a writer (loader / drawing
//                engine). Display wins in the active region, the writer wins
//                in blanking, and a starvation limit forces a writer slot
//                during long active periods.
//  Ports       : clk_i/rst_i          - pixel clock, sync active-high reset
//                blank_i              - 1 during horizontal/vertical blanking
//                disp_req/addr/gnt    - display read request channel
//                disp_valid/data      - display read return
//                wr_req/addr/data/gnt - writer channel
//                mem_*                - registered BSRAM command, read data in
//                stall_cnt_o          - writer stall statistics
//  Config      : FB_ARB_STATS_EN - build the stall counter; otherwise
//                stall_cnt_o is tied to 0
//  Revision    : 1.0  initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              blank_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_gnt_o,
    output logic              disp_valid_o,
    output logic [DATA_W-1:0] disp_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [15:0]       stall_cnt_o
);

    localparam int                  c_starve_w   = $clog2(STARVE_MAX + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);

    logic [c_starve_w-1:0] r_starve;
    logic                  w_starved;
    logic                  w_wr_wins;
    logic                  w_any_gnt;
    arb_state_t            r_state;
    arb_state_t            w_state_nxt;

    // ------------------------------------------------------------------
    // Grant: combinational, at most one per cycle. The writer takes the
    // slot on contention only in blanking or once it has waited
    // STARVE_MAX cycles; a lone request is always served.
    // ------------------------------------------------------------------
    assign w_starved  = (r_starve == c_starve_max);
    assign w_wr_wins  = blank_i | w_starved;
    assign wr_gnt_o   = ~rst_i & wr_req_i   & (~disp_req_i | w_wr_wins);
    assign disp_gnt_o = ~rst_i & disp_req_i & ~(wr_req_i & w_wr_wins);
    assign w_any_gnt  = wr_gnt_o | disp_gnt_o;

    // Consecutive cycles the writer has been kept waiting
    always_ff @(posedge clk_i) begin
        if (rst_i || !wr_req_i || wr_gnt_o) begin
            r_starve <= '0;
        end else if (!w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory command FSM: ACCESS for the cycle following any grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_any_gnt) begin
            w_state_nxt = ST_ACCESS;
        end
    end

    assign mem_ce_o = (r_state == ST_ACCESS);

    // Address/data captured from the winning requester. Between accesses
    // the address and write data hold; only the write strobe drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (wr_gnt_o) begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= wr_addr_i;
            mem_wdata_o <= wr_data_i;
        end else if (disp_gnt_o) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= disp_addr_i;
        end else begin
            mem_we_o    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read return: a read on the memory port surfaces RD_LAT cycles later
    // ------------------------------------------------------------------
    fb_rdpipe #(
        .DEPTH (RD_LAT)
    ) u_rdpipe (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_issue (mem_ce_o & ~mem_we_o),
        .o_valid (disp_valid_o)
    );

    assign disp_data_o = mem_rdata_i;

    // ------------------------------------------------------------------
    // Writer stall statistics. A forced slot closes a run of STARVE_MAX
    // waiting cycles, each of which lands in this one register.
    // ------------------------------------------------------------------
`ifdef FB_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (wr_req_i && !wr_gnt_o && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_arbiter
//  Description : Self-checking bench for fb_arbiter. A driver applies
//                directed and random requests, predicts each cycle's grant
//                from the arbitration rules and queues the expected memory
//                command and read returns; a monitor pops and compares them
//                as the DUT presents its registered outputs. A behavioural
//                BSRAM backs the memory port.
//  Config      : FB_ARB_STATS_EN - expect a live stall counter
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fb_arbiter;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 8;
    localparam int N_RAND     = 2500;
    localparam int MEM_WORDS  = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              blank_i;
    logic              disp_req_i;
    logic [ADDR_W-1:0] disp_addr_i;
    logic              disp_gnt_o;
    logic              disp_valid_o;
    logic [DATA_W-1:0] disp_data_o;
    logic              wr_req_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_gnt_o;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [15:0]       stall_cnt_o;

    fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .blank_i      (blank_i),
        .disp_req_i   (disp_req_i),
        .disp_addr_i  (disp_addr_i),
        .disp_gnt_o   (disp_gnt_o),
        .disp_valid_o (disp_valid_o),
        .disp_data_o  (disp_data_o),
        .wr_req_i     (wr_req_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_gnt_o     (wr_gnt_o),
        .mem_ce_o     (mem_ce_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- behavioural single-port BSRAM ----------------
    logic [DATA_W-1:0] init_val [MEM_WORDS];
    logic [DATA_W-1:0] bram     [MEM_WORDS];
    logic [DATA_W-1:0] rd_pipe  [RD_LAT];
    bit                bram_init = 1'b0;

    always @(posedge clk_i) begin
        if (!bram_init) begin
            for (int i = 0; i < MEM_WORDS; i++) bram[i] <= init_val[i];
            bram_init <= 1'b1;
        end else begin
            if (mem_ce_o && mem_we_o)  bram[mem_addr_o] <= mem_wdata_o;
            if (mem_ce_o && !mem_we_o) rd_pipe[0]       <= bram[mem_addr_o];
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata_i = rd_pipe[RD_LAT-1];

    // ---------------- reference model & scoreboard ----------------
    typedef struct {
        bit                zero;
        bit                ce;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                stall;
    } cmd_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_t;

    cmd_t              cmd_q [$];
    rd_t               rd_q  [$];
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    int                waited    = 0;   // cycles the writer has been refused
    int                stall_exp = 0;
    int                checks    = 0;
    int                errors    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus plus its predicted outcome
    task automatic step(input logic rst, input logic blank,
                        input logic dreq, input logic [ADDR_W-1:0] daddr,
                        input logic wreq, input logic [ADDR_W-1:0] waddr,
                        input logic [DATA_W-1:0] wdata,
                        output logic dg, output logic wg);
        cmd_t c;
        rd_t  r;
        logic exp_wg;
        logic exp_dg;
        @(negedge clk_i);
        rst_i       = rst;
        blank_i     = blank;
        disp_req_i  = dreq;
        disp_addr_i = daddr;
        wr_req_i    = wreq;
        wr_addr_i   = waddr;
        wr_data_i   = wdata;
        #2;
        exp_wg = 1'b0;
        exp_dg = 1'b0;
        if (!rst) begin
            if (wreq && (!dreq || blank || waited >= STARVE_MAX)) exp_wg = 1'b1;
            else if (dreq)                                         exp_dg = 1'b1;
        end
        check("wr_gnt",   32'(wr_gnt_o),   32'(exp_wg));
        check("disp_gnt", 32'(disp_gnt_o), 32'(exp_dg));

        if (rst)                                            stall_exp = 0;
        else if (wreq && !exp_wg && stall_exp < 16'hFFFF)   stall_exp++;

        c.zero  = rst;
        c.ce    = exp_wg | exp_dg;
        c.we    = exp_wg;
        c.addr  = exp_wg ? waddr : daddr;
        c.wdata = wdata;
`ifdef FB_ARB_STATS_EN
        c.stall = stall_exp;
`else
        c.stall = 0;
`endif
        cmd_q.push_back(c);

        if (rst) rd_q.delete();
        if (exp_wg) ref_mem[waddr] = wdata;
        if (exp_dg) begin
            r.due  = cyc + 1 + RD_LAT;
            r.data = ref_mem[daddr];
            rd_q.push_back(r);
        end

        if (rst || !wreq || exp_wg) waited = 0;
        else if (waited < STARVE_MAX) waited++;

        dg = exp_dg;
        wg = exp_wg;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            cmd_t c;
            logic exp_v;
            @(posedge clk_i);
            #1;
            if (cmd_q.size() > 0) begin
                c = cmd_q.pop_front();
                check("mem_ce", 32'(mem_ce_o), 32'(c.ce));
                check("mem_we", 32'(mem_we_o), 32'(c.we));
                if (c.zero) begin
                    check("mem_addr_rst",  32'(mem_addr_o),  32'd0);
                    check("mem_wdata_rst", 32'(mem_wdata_o), 32'd0);
                end else if (c.ce) begin
                    check("mem_addr", 32'(mem_addr_o), 32'(c.addr));
                    if (c.we) check("mem_wdata", 32'(mem_wdata_o), 32'(c.wdata));
                end
                check("stall_cnt", 32'(stall_cnt_o), 32'(c.stall));
            end
            exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
            check("disp_valid", 32'(disp_valid_o), 32'(exp_v));
            if (exp_v) begin
                if (disp_valid_o) check("disp_data", 32'(disp_data_o), 32'(rd_q[0].data));
                void'(rd_q.pop_front());
            end
            while ((rd_q.size() > 0) && (rd_q[0].due < cyc)) void'(rd_q.pop_front());
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic              dg;
        logic              wg;
        logic              dp;
        logic              wp;
        logic              blank;
        logic              r;
        logic [ADDR_W-1:0] da;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        int                slot;

        rst_i = 1'b1; blank_i = 1'b0; disp_req_i = 1'b0; wr_req_i = 1'b0;
        disp_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            init_val[i] = DATA_W'($urandom);
            ref_mem[i]  = init_val[i];
        end

        // Reset held with both requesters asking
        repeat (3) step(1'b1, 1'b1, 1'b1, 11'h010, 1'b1, 11'h020, 16'h1234, dg, wg);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, dg, wg);

        // Display-only read during active
        step(1'b0, 1'b0, 1'b1, 11'h010, 1'b0, '0, '0, dg, wg);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, dg, wg);

        // Contention in blanking: writer first, display the next cycle,
        // reading back the freshly written word
        step(1'b0, 1'b1, 1'b1, 11'h7F0, 1'b1, 11'h7F0, 16'hA5C3, dg, wg);
        step(1'b0, 1'b1, 1'b1, 11'h7F0, 1'b0, '0, '0, dg, wg);
        repeat (3) step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, dg, wg);

        // Starvation in active: fresh reset so the stall counter starts at 0
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, dg, wg);
        slot = 0;
        da   = 11'h100;
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, 1'b0, 1'b1, da, 1'b1, 11'h3C5, 16'h5A5A, dg, wg);
            if (dg) da = da + 1'b1;
            if (wg) begin
                slot = n;
                break;
            end
        end
        check("starve_slot", 32'(slot), 32'd9);
        step(1'b0, 1'b0, 1'b1, da, 1'b0, '0, '0, dg, wg);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, dg, wg);

        // Reset mid-read: the in-flight return must be discarded
        step(1'b0, 1'b0, 1'b1, 11'h055, 1'b0, '0, '0, dg, wg);
        step(1'b1, 1'b0, 1'b1, 11'h056, 1'b0, '0, '0, dg, wg);
        step(1'b0, 1'b0, 1'b1, 11'h057, 1'b0, '0, '0, dg, wg);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, dg, wg);

        // Random traffic honouring the hold-until-granted protocol
        dp = 1'b0; wp = 1'b0; blank = 1'b0;
        da = '0; wa = '0; wd = '0;
        repeat (N_RAND) begin
            if (!dp && ($urandom_range(0, 3) != 0)) begin
                dp = 1'b1;
                da = ADDR_W'($urandom);
            end
            if (!wp && ($urandom_range(0, 2) == 0)) begin
                wp = 1'b1;
                wa = ADDR_W'($urandom);
                wd = DATA_W'($urandom);
            end
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            r = ($urandom_range(0, 299) == 0);
            step(r, blank, dp, da, wp, wa, wd, dg, wg);
            if (dg || r) dp = 1'b0;
            if (wg || r) wp = 1'b0;
        end

        // Drain outstanding returns
        repeat (RD_LAT + 4) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, dg, wg);
        check("rd_drain", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
